// File: rtl/recon_scorer.sv
// recon_scorer: thresholds nine sigmoid outputs against the captured input pattern, one element per cycle.
// Optional macro RECON_ERR_SUM_EN builds the |target-y| accumulator; otherwise abs_err_sum is tied to zero.
module recon_scorer #(
   parameter logic signed [19:0] THRESH       = 20'sh08000,
   parameter logic        [3:0]  MAX_MISMATCH = 4'd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8:0]         x_in,
   input  logic signed [19:0] y_0,
   input  logic signed [19:0] y_1,
   input  logic signed [19:0] y_2,
   input  logic signed [19:0] y_3,
   input  logic signed [19:0] y_4,
   input  logic signed [19:0] y_5,
   input  logic signed [19:0] y_6,
   input  logic signed [19:0] y_7,
   input  logic signed [19:0] y_8,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8:0]         recon,
   output logic [3:0]         mismatch,
   output logic               pass,
   output logic [23:0]        abs_err_sum
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, state_nx;
   logic [3:0] idx;
   logic [8:0] x_r;
   logic signed [19:0] y_r [9];
   logic signed [19:0] y_sel;
   logic bit_r;
   logic [3:0] mis_nx;
   logic accept;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = (state == IDLE && in_valid) ? SCAN :
                 (state == SCAN && idx == 4'd8) ? DONE :
                 (state == DONE && out_ready) ? IDLE : state;
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end
   always_comb begin
      accept = state == IDLE && in_valid;
      y_sel  = y_r[idx];
      bit_r  = y_sel >= THRESH;
      mis_nx = mismatch + {3'b000, bit_r ^ x_r[idx]};
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx      <= 4'd0;
         x_r      <= 9'h0;
         recon    <= 9'h0;
         mismatch <= 4'd0;
         pass     <= 1'b1;
         for (int i = 0; i < 9; i++) y_r[i] <= 20'sh0;
      end else if (accept) begin
         idx      <= 4'd0;
         x_r      <= x_in;
         recon    <= 9'h0;
         mismatch <= 4'd0;
         pass     <= 1'b1;
         y_r      <= '{y_0, y_1, y_2, y_3, y_4, y_5, y_6, y_7, y_8};
      end else if (state == SCAN) begin
         idx        <= idx == 4'd8 ? idx : idx + 4'd1;
         recon[idx] <= bit_r;
         mismatch   <= mis_nx;
         pass       <= mis_nx <= MAX_MISMATCH;
      end
`ifdef RECON_ERR_SUM_EN
   logic signed [20:0] diff;
   logic [20:0] mag;
   logic [23:0] acc;
   // 21 bits covers the worst case 1.0 - (-8.0) = 9.0 without overflow
   always_comb begin
      diff = (x_r[idx] ? 21'sh10000 : 21'sh0) - {y_sel[19], y_sel};
      mag  = diff[20] ? -diff : diff;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= 24'h0;
      else if (accept) acc <= 24'h0;
      else if (state == SCAN) acc <= acc + {3'b000, mag};
   assign abs_err_sum = acc;
`else
   assign abs_err_sum = 24'h0;
`endif
endmodule

// File: tb/tb_recon_scorer.sv
// tb_recon_scorer: directed frames with hand-computed scores, latency, hold, and mid-scan reset checks.
module tb_recon_scorer;
   logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
   logic [8:0] x_in = 9'h0;
   logic signed [19:0] y [9];
   logic in_ready, out_valid, pass;
   logic [8:0] recon;
   logic [3:0] mismatch;
   logic [23:0] abs_err_sum;
   int checks = 0, errors = 0;
   int lat;
   logic seen;
   logic [8:0] h_recon;
   logic [3:0] h_mis;
   logic [23:0] h_err;

   recon_scorer #(.THRESH(20'sh08000), .MAX_MISMATCH(4'd1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
      .y_0(y[0]), .y_1(y[1]), .y_2(y[2]), .y_3(y[3]), .y_4(y[4]),
      .y_5(y[5]), .y_6(y[6]), .y_7(y[7]), .y_8(y[8]),
      .out_valid(out_valid), .out_ready(out_ready), .recon(recon),
      .mismatch(mismatch), .pass(pass), .abs_err_sum(abs_err_sum)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] e(input logic [23:0] v);
`ifdef RECON_ERR_SUM_EN
      return v;
`else
      return 24'h0;
`endif
   endfunction

   task automatic set_all(input logic signed [19:0] v);
      for (int i = 0; i < 9; i++) y[i] = v;
   endtask

   // accepts a frame, scrambles the live inputs, then measures edges to out_valid
   task automatic send(input logic [8:0] x);
      check("ready_idle", in_ready, 1'b1);
      x_in = x;
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      check("ready_busy", in_ready, 1'b0);
      x_in = ~x;
      set_all(20'sh80000);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, 9);
   endtask

   task automatic result(input string tag, input logic [8:0] r, input logic [3:0] m,
                         input logic p, input logic [23:0] err);
      check({tag, ".recon"}, recon, r);
      check({tag, ".mismatch"}, mismatch, m);
      check({tag, ".pass"}, pass, p);
      check({tag, ".err"}, abs_err_sum, err);
   endtask

   task automatic consume();
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check("back_idle", in_ready, 1'b1);
      check("valid_drop", out_valid, 1'b0);
   endtask

   initial begin
      set_all(20'sh0);
      #2 rst_n = 0;
      #1;
      result("reset", 9'h0, 4'd0, 1'b1, 24'h0);
      check("reset.valid", out_valid, 1'b0);
      check("reset.ready", in_ready, 1'b1);
      #10 rst_n = 1;
      @(posedge clk); #1;

      set_all(20'sh10000);
      send(9'h1FF);
      result("s1", 9'h1FF, 4'd0, 1'b1, e(24'h0));
      consume();

      set_all(20'sh08000);
      send(9'h000);
      result("s2", 9'h1FF, 4'd9, 1'b0, e(24'h048000));
      consume();

      set_all(20'sh0);
      y[0] = 20'sh80000;
      send(9'h001);
      result("s3", 9'h000, 4'd1, 1'b1, e(24'h090000));
      h_recon = recon; h_mis = mismatch; h_err = abs_err_sum;
      in_valid = 1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (!out_valid || in_ready || recon !== h_recon || mismatch !== h_mis || abs_err_sum !== h_err)
            seen = 1;
      end
      check("s4.hold", seen, 1'b0);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      in_valid = 0;
      check("s4.no_same_cycle_accept", in_ready, 1'b1);
      check("s4.valid_drop", out_valid, 1'b0);

      set_all(20'sh0);
      y[2] = 20'sh07FFF;
      y[5] = 20'sh08000;
      send(9'h024);
      result("s6a", 9'h020, 4'd1, 1'b1, e(24'h010001));
      consume();

      set_all(20'sh0);
      y[2] = 20'sh07FFF;
      y[5] = 20'sh08000;
      send(9'h020);
      result("s6b", 9'h020, 4'd0, 1'b1, e(24'h00FFFF));
      consume();

      set_all(20'sh10000);
      y[3] = 20'sh0;
      y[7] = 20'sh0;
      send(9'h1FF);
      result("s6c", 9'h177, 4'd2, 1'b0, e(24'h020000));
      consume();

      set_all(20'sh10000);
      x_in = 9'h1FF;
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (4) @(posedge clk);
      #1 rst_n = 0;
      #1;
      result("s5.rst", 9'h0, 4'd0, 1'b1, 24'h0);
      check("s5.valid", out_valid, 1'b0);
      #4 rst_n = 1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check("s5.no_valid", seen, 1'b0);
      set_all(20'sh08000);
      send(9'h000);
      result("s5.next", 9'h1FF, 4'd9, 1'b0, e(24'h048000));
      consume();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
